// File: rtl/sort_pkg.sv
// Shared types for the serial odd-even transposition sorter.
package sort_pkg;
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int SORT_ASC  = 0;
    localparam int SORT_DESC = 1;
endpackage

// File: rtl/cmp_swap.sv
// Two-element compare-swap; lo lands on the lower index, hi on the upper.
module cmp_swap
    import sort_pkg::*;
#(
    parameter int DW   = 8,
    parameter int MODE = SORT_ASC
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi
);
    logic swap;

    // Only strict disorder swaps, so equal elements keep their slots.
    assign swap = (MODE == SORT_ASC)  ? (a > b) :
                  (MODE == SORT_DESC) ? (a < b) : 1'b0;

    assign lo = swap ? b : a;
    assign hi = swap ? a : b;
endmodule

// File: rtl/stream_sort.sv
// Streaming sorter: load NUM beats, run NUM odd-even transposition phases, drain in order.
module stream_sort
    import sort_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NUM  = 8,
    parameter int MODE = SORT_ASC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);
    localparam int IW = $clog2(NUM);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [DW-1:0]   mem [NUM];
    logic [NUM*DW-1:0] even_nxt;
    logic [NUM*DW-1:0] odd_nxt;

    assign cnt_inc = cnt + ONE;

    for (genvar k = 0; k < NUM / 2; k++) begin : g_even
        cmp_swap #(.DW(DW), .MODE(MODE)) u_cs (
            .a  (mem[2*k]),
            .b  (mem[2*k+1]),
            .lo (even_nxt[(2*k)*DW +: DW]),
            .hi (even_nxt[(2*k+1)*DW +: DW])
        );
    end

    for (genvar k = 0; k < NUM / 2 - 1; k++) begin : g_odd
        cmp_swap #(.DW(DW), .MODE(MODE)) u_cs (
            .a  (mem[2*k+1]),
            .b  (mem[2*k+2]),
            .lo (odd_nxt[(2*k+1)*DW +: DW]),
            .hi (odd_nxt[(2*k+2)*DW +: DW])
        );
    end

    // The end slots have no partner in odd phases.
    assign odd_nxt[0 +: DW]             = mem[0];
    assign odd_nxt[(NUM-1)*DW +: DW]    = mem[NUM-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM; i++) mem[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        mem[cnt[IW-1:0]] <= in_data;
                        if (cnt == LAST) begin
                            state    <= SORT;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < NUM; i++)
                        mem[i] <= cnt[0] ? odd_nxt[i*DW +: DW] : even_nxt[i*DW +: DW];
                    if (cnt == LAST) begin
                        state <= OUT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                OUT: begin
                    // First OUT cycle only primes the output register from the final array.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= mem[cnt[IW-1:0]];
                        out_last  <= (cnt == LAST);
                    end else if (out_ready) begin
                        if (out_last) begin
                            state     <= LOAD;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt      <= cnt_inc;
                            out_data <= mem[cnt_inc[IW-1:0]];
                            out_last <= (cnt_inc == LAST);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_sort.sv
// Scoreboard bench: ascending and descending sorters run in lockstep on shared stimulus.
`timescale 1ns/1ps
module tb_stream_sort;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       ir_a, ov_a, ol_a, busy_a;
    logic       ir_d, ov_d, ol_d, busy_d;
    logic [7:0] od_a, od_d;

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0] sb_a [$];
    logic [8:0] sb_d [$];
    logic [8:0] ea, ed;

    always #5 clk = ~clk;

    stream_sort #(.DW(8), .NUM(8), .MODE(0)) dut_asc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_last(ol_a), .busy(busy_a)
    );

    stream_sort #(.DW(8), .NUM(8), .MODE(1)) dut_desc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_d), .in_data(in_data),
        .out_valid(ov_d), .out_ready(out_ready), .out_data(od_d), .out_last(ol_d), .busy(busy_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ov_a && out_ready) begin
            if (sb_a.size() == 0) chk("asc unexpected beat", 1, 0);
            else begin
                ea = sb_a.pop_front();
                chk("asc data", od_a, ea[7:0]);
                chk("asc last", ol_a, ea[8]);
            end
        end
        if (rst_n && ov_d && out_ready) begin
            if (sb_d.size() == 0) chk("desc unexpected beat", 1, 0);
            else begin
                ed = sb_d.pop_front();
                chk("desc data", od_d, ed[7:0]);
                chk("desc last", ol_d, ed[8]);
            end
        end
    end

    // Frames are written first-element-leftmost; descending expectation is the ascending one reversed.
    task automatic expect_frame(input logic [63:0] asc);
        for (int i = 0; i < 8; i++) begin
            sb_a.push_back({i == 7, asc[63-8*i -: 8]});
            sb_d.push_back({i == 7, asc[8*i+7 -: 8]});
        end
    endtask

    task automatic send_frame(input logic [63:0] f, input bit gaps);
        int n;
        for (int i = 0; i < 8; i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                repeat (i % 2 + 2) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = f[63-8*i -: 8];
            n = 0;
            while (!ir_a && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("in_ready wait", ir_a, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_latency();
        int n = 0;
        while (!ov_a && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first out_valid latency", n, 9);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_a.size() != 0 || sb_d.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain queue", sb_a.size() + sb_d.size(), 0);
        chk("in_ready after last", ir_a, 1);
        chk("out_valid after last", ov_a, 0);
        chk("busy after last", busy_a, 0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, " out_valid"}, {ov_a, ov_d}, 0);
        chk({tag, " out_data"}, {od_a, od_d}, 0);
        chk({tag, " out_last"}, {ol_a, ol_d}, 0);
        chk({tag, " busy"}, {busy_a, busy_d}, 0);
        chk({tag, " in_ready"}, {ir_a, ir_d}, 2'b11);
        sb_a.delete();
        sb_d.delete();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " in_ready after release"}, ir_a, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #11;
        chk("reset in_ready", {ir_a, ir_d}, 2'b11);
        chk("reset out_valid", {ov_a, ov_d}, 0);
        chk("reset busy", {busy_a, busy_d}, 0);
        chk("reset out_data", {od_a, od_d}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        expect_frame(64'h0005123C7A7A81FF);
        send_frame(64'h3C05FF007A7A1281, 1'b0);
        check_latency();
        wait_drain();

        // Reverse-sorted worst case; junk on in_valid while busy must be ignored.
        expect_frame(64'hF8F9FAFBFCFDFEFF);
        send_frame(64'hFFFEFDFCFBFAF9F8, 1'b0);
        chk("in_ready in SORT", ir_a, 0);
        chk("busy in SORT", busy_a, 1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        check_latency();
        in_valid = 1'b0;
        wait_drain();

        expect_frame(64'h5555555555555555);
        send_frame(64'h5555555555555555, 1'b0);
        wait_drain();

        // Input gaps plus a 5-cycle stall on output beat 3.
        expect_frame(64'h0005123C7A7A81FF);
        send_frame(64'h3C05FF007A7A1281, 1'b1);
        n = 0;
        while (sb_a.size() != 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach beat 3", sb_a.size(), 5);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall out_valid", {ov_a, ov_d}, 2'b11);
            chk("stall asc data", od_a, 8'h3C);
            chk("stall desc data", od_d, 8'h7A);
            chk("stall out_last", {ol_a, ol_d}, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_drain();

        expect_frame(64'h0102030405060708);
        send_frame(64'h0102030405060708, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        async_reset("sort rst");
        expect_frame(64'h1020304050607080);
        send_frame(64'h8070605040302010, 1'b0);
        wait_drain();

        expect_frame(64'h1122A0B0C0D0E0F0);
        send_frame(64'hA0B0C0D0E0F01122, 1'b0);
        n = 0;
        while (sb_a.size() != 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach beat 4", sb_a.size(), 4);
        async_reset("out rst");
        expect_frame(64'h1122334455667788);
        send_frame(64'h2211443366558877, 1'b0);
        wait_drain();

        // Loaded immediately after the previous frame's last handshake.
        expect_frame(64'h0001020306070809);
        send_frame(64'h0100090803020706, 1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
